clk_en_gen: RTL and testbench

//  Multi-channel programmable clock-enable generator, successor to the fixed 25-bit divider.

---
 rtl/clk_en_gen.sv | 128 ++++++++++++
 tb/tb_clk_en_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle tick every (div+1) clk cycles, periodic or one-shot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | channel stopped, counter held at 0, waiting for ch_enable
// RUN     | counting up to div_q, tick on terminal count
// DONE    | one-shot fired, parked until ch_enable drops
module clk_en_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 25,
  parameter int unsigned DEFAULT_DIV = 33554431
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_enable_i,
  input  logic [NUM_CH-1:0] ch_oneshot_i,
  input  logic [NUM_CH-1:0] div_load_i,
  input  logic [DIV_W-1:0]  div_value_i,
  input  logic              sync_clr_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] active_o,
  output logic              tick_any_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] tick_d;
  logic              tick_any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_nxt;
    logic             term_cnt;

    assign term_cnt = (cnt_q == div_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        div_q   <= DEF_DIV;
        mode_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        mode_q  <= mode_d;
        tick_q  <= tick_nxt;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      mode_d   = mode_q;
      tick_nxt = 1'b0;

      // The divisor register accepts a load in every state, independent of enable.
      if (div_load_i[g]) begin
        div_d = div_value_i;
      end

      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (ch_enable_i[g]) begin
            state_d = ST_RUN;
            mode_d  = ch_oneshot_i[g];
          end
        end
        ST_RUN: begin
          if (!ch_enable_i[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (div_load_i[g] || sync_clr_i) begin
            cnt_d = '0;
          end else if (term_cnt) begin
            tick_nxt = 1'b1;
            cnt_d    = '0;
            if (mode_q) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          cnt_d = '0;
          if (!ch_enable_i[g]) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign tick_d[g]   = tick_nxt;
    assign tick_o[g]   = tick_q;
    assign active_o[g] = (state_q == ST_RUN);
  end

  // Registered from the next-state ticks so it lines up with tick_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_any_q <= 1'b0;
    end else begin
      tick_any_q <= |tick_d;
    end
  end

  assign tick_any_o = tick_any_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with DEFAULT_DIV=3, four channels, 8-bit divisors.
module tb_clk_en_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] ch_oneshot;
  logic [NUM_CH-1:0] div_load;
  logic [DIV_W-1:0]  div_value;
  logic              sync_clr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;
  logic              tick_any;

  int checks = 0;
  int errors = 0;

  clk_en_gen #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_enable_i(ch_enable),
    .ch_oneshot_i(ch_oneshot),
    .div_load_i(div_load),
    .div_value_i(div_value),
    .sync_clr_i(sync_clr),
    .tick_o(tick),
    .active_o(active),
    .tick_any_o(tick_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ch_enable  = '0;
    ch_oneshot = '0;
    div_load   = '0;
    div_value  = '0;
    sync_clr   = 1'b0;

    #22;
    chk("rst_tick", tick, 0);
    chk("rst_active", active, 0);
    chk("rst_tick_any", tick_any, 0);
    step();
    rst = 1'b0;

    // 1: default divisor 3 on ch0 -> ticks at edges 4, 8, 12
    ch_enable[0] = 1'b1;
    step();
    chk("t1_active_e0", active[0], 1);
    chk("t1_tick_e0", tick[0], 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick", tick[0], (k % 4 == 0));
      chk("t1_tick_any", tick_any, (k % 4 == 0));
    end
    ch_enable[0] = 1'b0;
    step();
    chk("t1_active_off", active[0], 0);

    // 2: div 0 loaded together with enable on ch1 -> tick every cycle
    div_value = 8'd0;
    div_load  = 4'b0010;
    ch_enable[1] = 1'b1;
    step();
    div_load = '0;
    chk("t2_active_e0", active[1], 1);
    chk("t2_tick_e0", tick[1], 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t2_tick", tick[1], 1);
    end
    ch_enable[1] = 1'b0;
    step();
    chk("t2_tick_off", tick[1], 0);
    chk("t2_active_off", active[1], 0);

    // 3: ch2 one-shot with div 5
    div_value = 8'd5;
    div_load  = 4'b0100;
    step();
    div_load = '0;
    chk("t3_idle_load_active", active[2], 0);
    ch_oneshot[2] = 1'b1;
    ch_enable[2]  = 1'b1;
    step();
    chk("t3_active_e0", active[2], 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t3_tick", tick[2], (k == 6));
      chk("t3_active", active[2], (k < 6));
    end
    ch_enable[2] = 1'b0;
    step();
    chk("t3_idle_active", active[2], 0);
    ch_enable[2] = 1'b1;
    step();
    chk("t3_rearm_active", active[2], 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t3_rearm_tick", tick[2], (k == 6));
    end
    ch_enable[2]  = 1'b0;
    ch_oneshot[2] = 1'b0;
    step();

    // 4: sync_clr phase alignment, ch0 div 9 and ch3 div 4
    div_value = 8'd9;
    div_load  = 4'b0001;
    step();
    div_value = 8'd4;
    div_load  = 4'b1000;
    step();
    div_load = '0;
    ch_enable = 4'b1001;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t4_pre_tick", tick, 0);
    end
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("t4_sync_tick", tick, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t4_tick3", tick[3], (k == 5 || k == 10));
      chk("t4_tick0", tick[0], (k == 10));
      chk("t4_tick_any", tick_any, (k == 5 || k == 10));
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t4_gap_tick3", tick[3], 0);
    end
    // ch3 is at terminal count here; the clear must swallow the tick
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("t4_tc_suppress", tick[3], 0);
    chk("t4_tc_suppress_any", tick_any, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t4_post_tick3", tick[3], (k == 5));
      chk("t4_post_tick0", tick[0], 0);
    end
    ch_enable = '0;
    step();

    // 5: mid-count divisor reload on ch0 (div 7, cnt 5 -> div 2)
    div_value = 8'd7;
    div_load  = 4'b0001;
    step();
    div_load = '0;
    ch_enable[0] = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t5_pre_tick", tick[0], 0);
    end
    div_value = 8'd2;
    div_load  = 4'b0001;
    step();
    div_load = '0;
    chk("t5_load_tick", tick[0], 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t5_tick", tick[0], (k % 3 == 0));
    end

    // 6: async reset right after a tick, then restart at default divisor
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_active", active, 0);
    chk("t6_rst_tick_any", tick_any, 0);
    step();
    rst = 1'b0;
    chk("t6_held_active", active[0], 0);
    step();
    chk("t6_active_e0", active[0], 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6_tick", tick[0], (k % 4 == 0));
    end
    ch_enable = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
